// File: rtl/btn_filter_if.sv
// rtl/btn_filter_if.sv - button filter pin bundle: raw pins in, debounced level and event pulses out
interface btn_filter_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;
    logic [N_BTN-1:0] btn_hold;

    // Board/stimulus side: drives the raw pins and consumes the clean outputs.
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  btn_hold
    );

    // Filter side.
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output btn_hold
    );
endinterface

// File: rtl/btn_filter.sv
// rtl/btn_filter.sv - per-channel 2-flop sync + stable-window debounce; optional long-press via BTN_FILTER_HOLD_EN
module btn_filter #(
    parameter int N_BTN         = 4,
    parameter int STABLE_CYCLES = 500000,
    parameter int HOLD_CYCLES   = 100000000
) (
    input  logic         clk,
    input  logic         rst,
    btn_filter_if.slave  bus
);
    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [N_BTN-1:0] s0;
    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] rise_q;
    logic [N_BTN-1:0] fall_q;
    logic [CW-1:0]    cnt [N_BTN];

    // Two-flop synchroniser; only s1 is trusted downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= bus.btn_raw;
            s1 <= s0;
        end
    end

    // Stable-window filter: a differing s1 must persist STABLE_CYCLES samples before it is accepted;
    // any return to the current level restarts the window. Pulses default low so they last one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                rise_q[i] <= 1'b0;
                fall_q[i] <= 1'b0;
                if (s1[i] == level_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    level_q[i] <= s1[i];
                    cnt[i]     <= '0;
                    rise_q[i]  <= s1[i];
                    fall_q[i]  <= ~s1[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign bus.btn_level = level_q;
    assign bus.btn_rise  = rise_q;
    assign bus.btn_fall  = fall_q;

`ifdef BTN_FILTER_HOLD_EN
    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    logic [HW-1:0]    hcnt [N_BTN];
    logic [N_BTN-1:0] hfired;
    logic [N_BTN-1:0] hold_q;

    // Long-press timer: counts while the level is high, saturates at HOLD_MAX, then fires once
    // (HOLD_CYCLES edges after the rise edge). hfired blocks repeats until the level drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            hfired <= '0;
            hold_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                hcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                hold_q[i] <= 1'b0;
                if (!level_q[i]) begin
                    hcnt[i]   <= '0;
                    hfired[i] <= 1'b0;
                end else if (hcnt[i] != HOLD_MAX) begin
                    hcnt[i] <= hcnt[i] + HOLD_ONE;
                end else if (!hfired[i]) begin
                    hold_q[i] <= 1'b1;
                    hfired[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.btn_hold = hold_q;
`else
    // Long-press path not built; HOLD_CYCLES is non-negative so this folds to constant 0.
    assign bus.btn_hold = {N_BTN{HOLD_CYCLES < 0}};
`endif

endmodule

// File: tb/tb_btn_filter.sv
// tb/tb_btn_filter.sv - directed bench for btn_filter (N_BTN=2, STABLE_CYCLES=4, HOLD_CYCLES=10)
module tb_btn_filter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btn_filter_if #(.N_BTN(2)) bif ();

    btn_filter #(
        .N_BTN(2),
        .STABLE_CYCLES(4),
        .HOLD_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rise_cnt[2], fall_cnt[2], hold_cnt[2];
    int first_rise[2], first_fall[2], first_hold[2];
    int first_both, overlap, hold_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges, tallying pulses; indices are 1-based edges counted from the first edge of the window.
    task automatic watch(input int n);
        for (int c = 0; c < 2; c++) begin
            rise_cnt[c] = 0; fall_cnt[c] = 0; hold_cnt[c] = 0;
            first_rise[c] = -1; first_fall[c] = -1; first_hold[c] = -1;
        end
        first_both = -1;
        overlap = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            for (int c = 0; c < 2; c++) begin
                if (bif.btn_rise[c] === 1'b1) begin rise_cnt[c]++; if (first_rise[c] < 0) first_rise[c] = k; end
                if (bif.btn_fall[c] === 1'b1) begin fall_cnt[c]++; if (first_fall[c] < 0) first_fall[c] = k; end
                if (bif.btn_hold[c] === 1'b1) begin hold_cnt[c]++; hold_total++; if (first_hold[c] < 0) first_hold[c] = k; end
            end
            if (bif.btn_rise === 2'b11 && first_both < 0) first_both = k;
            if ((bif.btn_rise & bif.btn_fall) !== 2'b00) overlap++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.btn_raw = 2'b00;
        repeat (3) tick();
        rst = 1'b0;
        n_cmp++; if (bif.btn_level !== 2'b00) begin n_bad++; $display("FAIL reset_level: got %b want 00", bif.btn_level); end
        n_cmp++; if (bif.btn_rise !== 2'b00) begin n_bad++; $display("FAIL reset_rise: got %b want 00", bif.btn_rise); end
        n_cmp++; if (bif.btn_fall !== 2'b00) begin n_bad++; $display("FAIL reset_fall: got %b want 00", bif.btn_fall); end
        n_cmp++; if (bif.btn_hold !== 2'b00) begin n_bad++; $display("FAIL reset_hold: got %b want 00", bif.btn_hold); end
        watch(4);
    endtask

    task automatic test_press();
        bif.btn_raw = 2'b01;
        watch(5);
        n_cmp++; if (bif.btn_level !== 2'b00) begin n_bad++; $display("FAIL press_early_level: got %b want 00", bif.btn_level); end
        n_cmp++; if (rise_cnt[0] !== 0) begin n_bad++; $display("FAIL press_early_rise: got %0d want 0", rise_cnt[0]); end
        tick();
        n_cmp++; if (bif.btn_level !== 2'b01) begin n_bad++; $display("FAIL press_level: got %b want 01", bif.btn_level); end
        n_cmp++; if (bif.btn_rise !== 2'b01) begin n_bad++; $display("FAIL press_rise: got %b want 01", bif.btn_rise); end
        n_cmp++; if (bif.btn_fall !== 2'b00) begin n_bad++; $display("FAIL press_fall: got %b want 00", bif.btn_fall); end
        tick();
        n_cmp++; if (bif.btn_rise !== 2'b00) begin n_bad++; $display("FAIL press_rise_one_cycle: got %b want 00", bif.btn_rise); end
        n_cmp++; if (bif.btn_level !== 2'b01) begin n_bad++; $display("FAIL press_level_held: got %b want 01", bif.btn_level); end
    endtask

    task automatic test_release();
        bif.btn_raw = 2'b00;
        watch(3);
        bif.btn_raw = 2'b01;
        watch(10);
        n_cmp++; if (fall_cnt[0] !== 0) begin n_bad++; $display("FAIL glitch_fall: got %0d want 0", fall_cnt[0]); end
        n_cmp++; if (bif.btn_level !== 2'b01) begin n_bad++; $display("FAIL glitch_level: got %b want 01", bif.btn_level); end
        bif.btn_raw = 2'b00;
        watch(10);
        n_cmp++; if (fall_cnt[0] !== 1) begin n_bad++; $display("FAIL release_fall_count: got %0d want 1", fall_cnt[0]); end
        n_cmp++; if (first_fall[0] !== 6) begin n_bad++; $display("FAIL release_fall_edge: got %0d want 6", first_fall[0]); end
        n_cmp++; if (rise_cnt[0] !== 0) begin n_bad++; $display("FAIL release_rise: got %0d want 0", rise_cnt[0]); end
        n_cmp++; if (bif.btn_level !== 2'b00) begin n_bad++; $display("FAIL release_level: got %b want 00", bif.btn_level); end
    endtask

    task automatic test_bounce();
        bif.btn_raw = 2'b01; tick();
        bif.btn_raw = 2'b00; tick();
        bif.btn_raw = 2'b01; tick();
        bif.btn_raw = 2'b00; tick();
        bif.btn_raw = 2'b01;
        watch(12);
        n_cmp++; if (rise_cnt[0] !== 1) begin n_bad++; $display("FAIL bounce_rise_count: got %0d want 1", rise_cnt[0]); end
        n_cmp++; if (first_rise[0] !== 6) begin n_bad++; $display("FAIL bounce_rise_edge: got %0d want 6", first_rise[0]); end
        n_cmp++; if (fall_cnt[0] !== 0) begin n_bad++; $display("FAIL bounce_fall: got %0d want 0", fall_cnt[0]); end
        bif.btn_raw = 2'b00;
        watch(10);
    endtask

    task automatic test_simultaneous();
        bif.btn_raw = 2'b11;
        watch(10);
        n_cmp++; if (first_both !== 6) begin n_bad++; $display("FAIL simul_rise_edge: got %0d want 6", first_both); end
        n_cmp++; if (rise_cnt[1] !== 1) begin n_bad++; $display("FAIL simul_rise1_count: got %0d want 1", rise_cnt[1]); end
        n_cmp++; if (bif.btn_level !== 2'b11) begin n_bad++; $display("FAIL simul_level: got %b want 11", bif.btn_level); end
        bif.btn_raw = 2'b00;
        watch(10);
        n_cmp++; if (fall_cnt[0] !== 1 || fall_cnt[1] !== 1) begin n_bad++; $display("FAIL simul_fall_count: got %0d/%0d want 1/1", fall_cnt[0], fall_cnt[1]); end
        n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL simul_rise_fall_overlap: got %0d want 0", overlap); end
    endtask

    task automatic test_reset_mid_count();
        bif.btn_raw = 2'b01;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({bif.btn_level, bif.btn_rise, bif.btn_fall} !== 6'b0) begin n_bad++; $display("FAIL rstmid_outputs: got %b want 000000", {bif.btn_level, bif.btn_rise, bif.btn_fall}); end
        watch(12);
        n_cmp++; if (rise_cnt[0] !== 1) begin n_bad++; $display("FAIL rstmid_rise_count: got %0d want 1", rise_cnt[0]); end
        n_cmp++; if (first_rise[0] !== 6) begin n_bad++; $display("FAIL rstmid_rise_edge: got %0d want 6", first_rise[0]); end
        n_cmp++; if (fall_cnt[0] !== 0) begin n_bad++; $display("FAIL rstmid_fall: got %0d want 0", fall_cnt[0]); end
        bif.btn_raw = 2'b00;
        watch(10);
    endtask

    task automatic test_hold();
`ifdef BTN_FILTER_HOLD_EN
        bif.btn_raw = 2'b01;
        watch(30);
        n_cmp++; if (first_rise[0] !== 6) begin n_bad++; $display("FAIL hold_rise_edge: got %0d want 6", first_rise[0]); end
        n_cmp++; if (hold_cnt[0] !== 1) begin n_bad++; $display("FAIL hold_count: got %0d want 1", hold_cnt[0]); end
        n_cmp++; if (first_hold[0] !== 16) begin n_bad++; $display("FAIL hold_edge: got %0d want 16", first_hold[0]); end
        n_cmp++; if (hold_cnt[1] !== 0) begin n_bad++; $display("FAIL hold_ch1: got %0d want 0", hold_cnt[1]); end
        bif.btn_raw = 2'b00;
        watch(10);
        bif.btn_raw = 2'b01;
        watch(6);
        n_cmp++; if (first_rise[0] !== 6) begin n_bad++; $display("FAIL short_rise_edge: got %0d want 6", first_rise[0]); end
        bif.btn_raw = 2'b00;
        watch(20);
        n_cmp++; if (first_fall[0] !== 6) begin n_bad++; $display("FAIL short_fall_edge: got %0d want 6", first_fall[0]); end
        n_cmp++; if (hold_cnt[0] !== 0) begin n_bad++; $display("FAIL short_hold: got %0d want 0", hold_cnt[0]); end
`else
        bif.btn_raw = 2'b01;
        watch(30);
        n_cmp++; if (hold_total !== 0) begin n_bad++; $display("FAIL hold_disabled_pulses: got %0d want 0", hold_total); end
        n_cmp++; if (bif.btn_hold !== 2'b00) begin n_bad++; $display("FAIL hold_disabled_level: got %b want 00", bif.btn_hold); end
        bif.btn_raw = 2'b00;
        watch(10);
`endif
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/btn_filter.md
Name: btn_filter

Overview:
- Upstream conditioning stage for the GPIO button path.
- Synchronises raw, asynchronous, bouncing button pins into the clock domain, then applies a per-channel stable-window filter.
- Outputs a clean debounced level plus single-cycle rise/fall event pulses, which feed the rising-edge pulse stage and the AXI-lite GPIO register logic.
- N_BTN channels are fully independent.

Parameters:
- N_BTN, 4, number of button channels (1..32).
- STABLE_CYCLES, 500000, consecutive clock cycles a new synced value must persist before it is accepted (5 ms at 100 MHz); minimum 2.
- HOLD_CYCLES, 100000000, cycles the debounced level must stay high before btn_hold fires (1 s at 100 MHz); used only with the optional feature; minimum 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  raw asynchronous button pins; bit i is channel i.
- btn_level  output  N_BTN  debounced level, registered.
- btn_rise  output  N_BTN  one-cycle pulse when btn_level goes 0->1, registered.
- btn_fall  output  N_BTN  one-cycle pulse when btn_level goes 1->0, registered.
- btn_hold  output  N_BTN  one-cycle long-press pulse; constant 0 when feature disabled.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: when rst=1 at a clk edge, the following all clear to 0:
  - sync flops
  - counters
  - btn_level, btn_rise, btn_fall, btn_hold
- rst overrides all other activity.
- Synchroniser (per channel):
  - Two flops: s0 <= btn_raw[i]; s1 <= s0.
  - Only s1 is used downstream.
  - Reset value of both flops is 0.
- Stable counter (per channel):
  - Width = clog2(STABLE_CYCLES).
  - If s1 == btn_level[i]: cnt <= 0.
  - If s1 != btn_level[i] and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - If s1 != btn_level[i] and cnt == STABLE_CYCLES-1:
    - btn_level[i] <= s1 and cnt <= 0.
    - btn_rise[i] <= s1 and btn_fall[i] <= ~s1, in the same edge.
  - Otherwise btn_rise[i] and btn_fall[i] <= 0, so each pulse lasts exactly one cycle.
- Latency: a raw change first sampled at edge E (constant afterwards) gives:
  - s1 valid after edge E+1;
  - btn_level and the pulse update at edge E+1+STABLE_CYCLES.
- Glitches: any return of s1 to the current level before the window completes zeroes cnt. A glitch of STABLE_CYCLES-1 samples or fewer never changes btn_level.
- Counter range: cnt never exceeds STABLE_CYCLES-1 and never wraps.
- Pulse spacing: rise and fall never assert together on one channel. Consecutive events on one channel are at least STABLE_CYCLES cycles apart.
- Channel independence: simultaneous events on different channels are independent, and multiple bits may pulse in the same cycle.
- Reset mid-count: the pending transition is discarded.
  - A button held high through reset produces a fresh btn_rise at the normal latency after rst deasserts.
  - No btn_fall is produced for the forced-0 reset level.

Optional Feature:
- Macro: BTN_FILTER_HOLD_EN.
- Defined:
  - Per-channel hold counter of width clog2(HOLD_CYCLES).
  - Cleared while btn_level[i]=0 or on rst.
  - While btn_level[i]=1 it increments each cycle, starting the cycle after btn_rise.
  - On reaching HOLD_CYCLES-1, btn_hold[i] pulses for one cycle (HOLD_CYCLES edges after the btn_rise edge).
  - The counter then saturates and does not repeat until btn_level falls.
  - A release before that point produces no btn_hold.
- Not defined: no hold counters are built and btn_hold is tied to 0.

Test Plan:
- Basic press (STABLE_CYCLES=4, N_BTN=2): rst high 3 cycles; btn_raw=2'b00 -> all outputs 0. Then btn_raw[0]=1 sampled at edge 10 -> btn_level[0]=1 after edge 15, btn_rise[0]=1 for exactly one cycle, btn_fall=0, channel 1 unchanged.
- Bounce rejection (STABLE_CYCLES=4): btn_raw[0] toggles 1,0,1,0,1 on successive edges, then holds 1 -> exactly one btn_rise[0], 5 cycles after the last 0->1 sample; no btn_fall.
- Release (STABLE_CYCLES=4): from level 1, btn_raw[0]=0 sampled at edge E -> btn_level[0]=0 and one-cycle btn_fall[0] at edge E+5. A 3-cycle low glitch instead -> no change.
- Simultaneous channels: both bits go 1 on the same edge -> btn_rise=2'b11 in the same cycle, and btn_level=2'b11.
- Reset mid-count: btn_raw[0]=1, rst pulsed 1 cycle while cnt=2 -> outputs 0 and no pulse at the old deadline. With btn_raw still 1, btn_rise[0] fires 5 edges after the first post-reset sampling edge.
- Hold (BTN_FILTER_HOLD_EN, HOLD_CYCLES=10):
  - Button held -> btn_hold[0] pulses exactly once, 10 cycles after btn_rise[0].
  - Released after 6 cycles -> no btn_hold.
  - Without the macro -> btn_hold stays 0.
